// File: rtl/input_module.sv
// Router ingress stage for one link.
// Buffers incoming 32-bit packets in a small FIFO, loads the oldest packet
// into a head register together with its XY route, and offers it to the
// crossbar as a one-hot valid/ready request. A forwarded-packet counter
// saturates at all-ones.
module input_module #(
    parameter int BUF_DEPTH = 4,
    parameter int X_COORD   = 0,
    parameter int Y_COORD   = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  in_packet,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [31:0]                  out_data,
    output logic [4:0]                   out_valid,
    input  logic [4:0]                   out_ready,
    output logic [CNT_WIDTH-1:0]         fwd_count,
    output logic [$clog2(BUF_DEPTH):0]   buf_count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
    localparam logic [3:0] X_C = X_COORD[3:0];
    localparam logic [3:0] Y_C = Y_COORD[3:0];

    // One-hot direction encoding: bit 0 N, 1 S, 2 E, 3 W, 4 Local.
    localparam logic [4:0] DIR_N = 5'b00001;
    localparam logic [4:0] DIR_S = 5'b00010;
    localparam logic [4:0] DIR_E = 5'b00100;
    localparam logic [4:0] DIR_W = 5'b01000;
    localparam logic [4:0] DIR_L = 5'b10000;

    typedef enum logic {
        HEAD_EMPTY = 1'b0,
        HEAD_VALID = 1'b1
    } head_state_t;

    // XY routing: resolve X first, then Y, otherwise deliver locally.
    function automatic logic [4:0] calc_route(input logic [7:0] dest);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [4:0] dir;
        dx = dest[7:4];
        dy = dest[3:0];
        if (dx > X_C) begin
            dir = DIR_E;
        end else if (dx < X_C) begin
            dir = DIR_W;
        end else if (dy > Y_C) begin
            dir = DIR_N;
        end else if (dy < Y_C) begin
            dir = DIR_S;
        end else begin
            dir = DIR_L;
        end
        return dir;
    endfunction

    logic [31:0]          mem_r [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    head_state_t          state_r;
    head_state_t          state_s;
    logic [31:0]          head_r;
    logic [4:0]           route_r;
    logic [CNT_WIDTH-1:0] fwd_r;

    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 xfer_s;
    logic [31:0]          rd_data_s;

    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign fifo_full_s  = (count_r == FULL_CNT);
    // Strict ingress: a pop in the same cycle never frees a slot for the write.
    assign push_s       = in_valid && !fifo_full_s;
    assign xfer_s       = (state_r == HEAD_VALID) && (|(route_r & out_ready));
    assign rd_data_s    = mem_r[rd_ptr_r];

    assign in_ready  = !fifo_full_s;
    assign out_data  = head_r;
    assign out_valid = route_r;
    assign fwd_count = fwd_r;
    assign buf_count = count_r;

    // FIFO storage write; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_packet;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head-stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= HEAD_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Head-stage next state and FIFO pop decision.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            HEAD_EMPTY: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_s = HEAD_VALID;
                end else begin
                    state_s = HEAD_EMPTY;
                end
            end
            HEAD_VALID: begin
                if (xfer_s) begin
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        state_s = HEAD_VALID;
                    end else begin
                        state_s = HEAD_EMPTY;
                    end
                end else begin
                    state_s = HEAD_VALID;
                end
            end
            default: begin
                state_s = HEAD_EMPTY;
            end
        endcase
    end

    // Head packet and registered route; route is cleared when the head empties
    // so out_valid is zero exactly in HEAD_EMPTY and never changes while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= 32'h0000_0000;
            route_r <= 5'b00000;
        end else if (pop_s) begin
            head_r  <= rd_data_s;
            route_r <= calc_route(rd_data_s[31:24]);
        end else if (xfer_s) begin
            route_r <= 5'b00000;
        end else begin
            route_r <= route_r;
        end
    end

    // Saturating count of completed transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_r <= {CNT_WIDTH{1'b0}};
        end else if (xfer_s && (fwd_r != {CNT_WIDTH{1'b1}})) begin
            fwd_r <= fwd_r + CNT_WIDTH'(1);
        end else begin
            fwd_r <= fwd_r;
        end
    end

endmodule

// File: tb/tb_input_module.sv
// Directed scoreboard bench for input_module (X=1, Y=1, depth 4).
module tb_input_module;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_packet;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready;
    logic [15:0] fwd_count;
    logic [2:0]  buf_count;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] sb[$];
    logic [31:0] pk[6];
    bit acc;

    input_module #(
        .BUF_DEPTH(4), .X_COORD(1), .Y_COORD(1), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_packet(in_packet), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fwd_count(fwd_count), .buf_count(buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference XY route for a router at (1,1).
    function automatic logic [4:0] exp_route(input logic [31:0] p);
        if (p[31:28] > 4'd1)      return 5'b00100;
        else if (p[31:28] < 4'd1) return 5'b01000;
        else if (p[27:24] > 4'd1) return 5'b00001;
        else if (p[27:24] < 4'd1) return 5'b00010;
        else                      return 5'b10000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluate one cycle at the negedge: record acceptance, score any transfer,
    // then advance to the next negedge.
    task automatic cycle(output bit accepted);
        logic [36:0] e;
        accepted = in_valid && in_ready;
        if (accepted) sb.push_back({exp_route(in_packet), in_packet});
        if (|(out_valid & out_ready)) begin
            check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("xfer_valid", 64'(out_valid), 64'(e[36:32]));
                check("xfer_data", 64'(out_data), 64'(e[31:0]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        bit a;
        for (int i = 0; i < budget; i++) cycle(a);
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_packet = 32'h0; out_ready = 5'b00000;
        pk[0] = 32'h2000_0010; pk[1] = 32'h0100_0011; pk[2] = 32'h1500_0012;
        pk[3] = 32'h1000_0013; pk[4] = 32'h1100_0014; pk[5] = 32'hF0F0_0015;
        @(negedge clk); @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_fwd", 64'(fwd_count), 64'd0);
        check("rst_buf", 64'(buf_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single packet to East, latency.
        out_ready = 5'b11111; in_packet = 32'h3100_00AA; in_valid = 1'b1;
        cycle(acc);
        check("t1_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
        check("t1_lat_valid0", 64'(out_valid), 64'd0);
        check("t1_lat_buf1", 64'(buf_count), 64'd1);
        cycle(acc);
        check("t1_valid_e", 64'(out_valid), 64'b00100);
        check("t1_data", 64'(out_data), 64'h3100_00AA);
        cycle(acc);
        check("t1_fwd", 64'(fwd_count), 64'd1);
        check("t1_idle", 64'(out_valid), 64'd0);

        // Route coverage, back-to-back W, N, S, L.
        in_valid = 1'b1;
        in_packet = 32'h0100_0001; cycle(acc);
        in_packet = 32'h1200_0002; cycle(acc);
        check("t2_w", 64'(out_valid), 64'b01000);
        in_packet = 32'h1000_0003; cycle(acc);
        check("t2_n", 64'(out_valid), 64'b00001);
        in_packet = 32'h1100_0004; cycle(acc);
        check("t2_s", 64'(out_valid), 64'b00010);
        in_valid = 1'b0;
        cycle(acc);
        check("t2_l", 64'(out_valid), 64'b10000);
        cycle(acc);
        check("t2_drain", 64'(sb.size()), 64'd0);
        check("t2_fwd", 64'(fwd_count), 64'd5);

        // Backpressure: 1 head + 4 buffered, sixth held by sender.
        out_ready = 5'b00000; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_packet = pk[i];
            cycle(acc);
            check("t3_accept", 64'(acc), 64'd1);
        end
        in_packet = pk[5];
        for (int i = 0; i < 2; i++) begin
            check("t3_in_ready", 64'(in_ready), 64'd0);
            check("t3_buf", 64'(buf_count), 64'd4);
            check("t3_hold_valid", 64'(out_valid), 64'(exp_route(pk[0])));
            check("t3_hold_data", 64'(out_data), 64'(pk[0]));
            cycle(acc);
        end
        // Full FIFO with a transfer: write still refused this cycle.
        out_ready = 5'b11111;
        cycle(acc);
        check("t5_refused", 64'(acc), 64'd0);
        check("t5_buf3", 64'(buf_count), 64'd3);
        check("t5_ready", 64'(in_ready), 64'd1);
        out_ready = 5'b00000;
        cycle(acc);
        check("t5_accepted", 64'(acc), 64'd1);
        check("t5_buf4", 64'(buf_count), 64'd4);
        check("t5_head", 64'(out_data), 64'(pk[1]));
        in_valid = 1'b0; out_ready = 5'b11111;
        drain("t3_drain", 5);
        check("t3_fwd", 64'(fwd_count), 64'd11);

        // Wrong-port ready is ignored.
        out_ready = 5'b11011; in_packet = 32'h3100_0001; in_valid = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle(acc);
        check("t4_held_valid", 64'(out_valid), 64'b00100);
        check("t4_held_data", 64'(out_data), 64'h3100_0001);
        check("t4_fwd_hold", 64'(fwd_count), 64'd11);
        out_ready = 5'b00100;
        drain("t4_drain", 1);
        check("t4_fwd", 64'(fwd_count), 64'd12);
        check("t4_idle", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-operation.
        out_ready = 5'b00000; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_packet = pk[i];
            cycle(acc);
        end
        in_valid = 1'b0;
        check("t6_buf3", 64'(buf_count), 64'd3);
        check("t6_head", 64'(out_valid), 64'(exp_route(pk[0])));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_ready", 64'(in_ready), 64'd1);
        check("t6_rst_buf", 64'(buf_count), 64'd0);
        check("t6_rst_fwd", 64'(fwd_count), 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 5'b11111; in_packet = 32'h0000_0055; in_valid = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        cycle(acc);
        check("t6_new_w", 64'(out_valid), 64'b01000);
        check("t6_new_data", 64'(out_data), 64'h0000_0055);
        drain("t6_drain", 1);
        check("t6_fwd", 64'(fwd_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/input_module.md
Name: input_module

Overview:
- Router ingress stage for one link (N, S, E, W or Local): buffers 32-bit packets arriving from an adjacent router or network interface.
- Computes the XY-routing direction for the head packet.
- Presents the packet to the crossbar with a one-hot per-direction valid/ready handshake.
- Its per-direction outputs drive the in_<dir>_data/valid/ready inputs of the five output modules.

Parameters:
- BUF_DEPTH, 4, input FIFO depth in packets; power of two, >=2
- X_COORD, 0, this router's X coordinate, 0..15
- Y_COORD, 0, this router's Y coordinate, 0..15
- CNT_WIDTH, 16, width of the forwarded-packet counter

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_packet  input  32  incoming packet; [31:28] dest_x, [27:24] dest_y, [23:0] payload
- in_valid  input  1  in_packet valid
- in_ready  output  1  FIFO can accept a packet
- out_data  output  32  head packet, broadcast to all five output modules
- out_valid  output  5  one-hot request; bit 0 N, 1 S, 2 E, 3 W, 4 Local
- out_ready  input  5  per-direction ready from output modules, same bit order
- fwd_count  output  CNT_WIDTH  packets forwarded since reset, saturating
- buf_count  output  $clog2(BUF_DEPTH)+1  packets held in the FIFO, excluding the head register

Behaviour:
- Reset values: FIFO empty, in_ready=1, out_data=0, out_valid=0, fwd_count=0, buf_count=0, head state HEAD_EMPTY.
- Reset is asynchronous; assertion mid-transfer discards all buffered and head packets with no partial output.
- Ingress:
  - in_ready = !fifo_full, strictly; there is no write-through when full, even if a pop occurs the same cycle.
  - A write occurs when in_valid && in_ready at a clock edge.
- Head stage FSM, two states:
  - HEAD_EMPTY: out_valid=0. If FIFO non-empty, pop one packet into the head register, compute its route, and go to HEAD_VALID.
  - HEAD_VALID: out_valid = registered one-hot route; out_data = head packet. The transfer completes when |(out_valid & out_ready).
    - On transfer with FIFO non-empty: pop the next packet into head in the same edge and stay in HEAD_VALID (back-to-back, 1 packet/cycle).
    - On transfer with FIFO empty: go to HEAD_EMPTY.
    - No transfer: head, route and out_valid hold stable. out_valid must not drop or change once asserted (no retraction).
- Route computation (XY, X first), done combinationally on the FIFO head and registered on load:
  - dest_x > X_COORD -> E; dest_x < X_COORD -> W.
  - Else dest_y > Y_COORD -> N; dest_y < Y_COORD -> S.
  - Else -> Local.
  - Exactly one out_valid bit is set whenever in HEAD_VALID.
- Latency: a packet written at edge k shows out_valid at edge k+1 when the FIFO is empty and the head is empty or transferring (2-stage pipeline). Sustained throughput is 1 packet/cycle.
- Simultaneous FIFO write and pop: both occur and the count is unchanged. Write into an empty FIFO is not visible to the head until the next edge.
- FIFO pointers wrap modulo BUF_DEPTH. Full/empty are distinguished by the count, or by an extra pointer bit.
- fwd_count increments by 1 on each completed transfer and saturates at all-ones.
- out_ready bits outside the asserted out_valid bit are ignored.

Test Plan:
- X_COORD=1, Y_COORD=1, all out_ready=1; send 0x3100_00AA -> out_valid=5'b00100 (E), out_data=0x3100_00AA two edges after acceptance; fwd_count=1.
- Route coverage: send dest (0,1), (1,2), (1,0), (1,1) back-to-back -> out_valid sequence W=01000, N=00001, S=00010, L=10000 on consecutive cycles; fwd_count=4.
- Backpressure: out_ready=0, send 6 packets with BUF_DEPTH=4 -> 1 in head, 4 in FIFO, in_ready=0 after the 5th acceptance, 6th held by the sender; out_valid/out_data stable throughout. Then release out_ready=5'b11111 -> all 6 emerge in order at 1/cycle.
- Wrong-port ready: head routed E, out_ready=5'b11011 -> no transfer, head held. Set out_ready[2]=1 -> transfer in 1 cycle.
- Full + simultaneous pop: FIFO full, head transfers, in_valid=1 -> write refused that cycle (in_ready=0). Next cycle in_ready=1 and the write is accepted; buf_count goes 4 -> 3 -> 4.
- Reset mid-operation: 3 packets buffered, head valid, assert rst_n=0 asynchronously -> out_valid=0, in_ready=1, buf_count=0, fwd_count=0 immediately. After release, a new packet routes normally.
